// File: rtl/xz_resolve_fifo.sv
// FWFT FIFO that resolves X/Z bits of 4-state input beats to a fixed fill value,
// recording a per-bit replacement mask, an X/Z beat counter and a control-line error flag.
module xz_resolve_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter bit          FILL  = 1'b0,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [4:3][3:0]          in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output bit   [4:3][3:0]          out_data,
  output bit   [4:3][3:0]          out_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         xz_cnt,
  output logic                     ctl_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [7:0]       mem_data_q [DEPTH];
  logic [7:0]       mem_mask_q [DEPTH];
  logic [7:0]       out_data_q, out_data_d;
  logic [7:0]       out_mask_q, out_mask_d;
  logic [CNT_W-1:0] xz_cnt_q, xz_cnt_d;
  logic             ctl_err_q, ctl_err_d;

  logic [7:0]    in_flat;
  logic [7:0]    res_data, res_mask;
  logic          valid_one, valid_xz;
  logic          push, pop;
  logic [PW-1:0] level_cur, level_after_pop, level_next;

  assign in_flat   = in_data;
  assign valid_one = (in_valid === 1'b1);
  assign valid_xz  = (in_valid !== 1'b0) && (in_valid !== 1'b1);

  assign level_cur = wr_q - rd_q;
  assign in_ready  = (level_cur != PW'(DEPTH));
  assign out_valid = (level_cur != '0);
  assign push      = valid_one && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    res_data = '0;
    res_mask = '0;
    for (int i = 0; i < 8; i++) begin
      if ((in_flat[i] === 1'b0) || (in_flat[i] === 1'b1)) begin
        res_data[i] = in_flat[i];
      end else begin
        res_data[i] = FILL;
        res_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    wr_d            = flush ? '0 : wr_q + PW'(push);
    rd_d            = flush ? '0 : rd_q + PW'(pop);
    level_after_pop = level_cur - PW'(pop);
    level_next      = flush ? '0 : level_after_pop + PW'(push);
    out_data_d      = out_data_q;
    out_mask_d      = out_mask_q;
    // Head register holds its value while empty; a beat landing in an empty FIFO bypasses memory.
    if (level_next != '0) begin
      if (level_after_pop == '0) begin
        out_data_d = res_data;
        out_mask_d = res_mask;
      end else begin
        out_data_d = mem_data_q[rd_d[AW-1:0]];
        out_mask_d = mem_mask_q[rd_d[AW-1:0]];
      end
    end
    xz_cnt_d = xz_cnt_q;
    if (push && (res_mask != '0) && (xz_cnt_q != '1)) begin
      xz_cnt_d = xz_cnt_q + 1'b1;
    end
    ctl_err_d = ctl_err_q | valid_xz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      out_data_q <= '0;
      out_mask_q <= '0;
      xz_cnt_q   <= '0;
      ctl_err_q  <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      out_data_q <= out_data_d;
      out_mask_q <= out_mask_d;
      xz_cnt_q   <= xz_cnt_d;
      ctl_err_q  <= ctl_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_q[AW-1:0]] <= res_data;
      mem_mask_q[wr_q[AW-1:0]] <= res_mask;
    end
  end

  assign out_data = out_data_q;
  assign out_mask = out_mask_q;
  assign level    = level_cur;
  assign xz_cnt   = xz_cnt_q;
  assign ctl_err  = ctl_err_q;

endmodule

// File: tb/tb_xz_resolve_fifo.sv
// Random and directed stimulus for xz_resolve_fifo, checked against a queue-based model;
// a second instance with a 2-bit counter exercises counter saturation on the same traffic.
module tb_xz_resolve_fifo;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] din = '0;
  logic       vin = 1'b0;
  logic       ordy = 1'b0;

  logic       in_ready, out_valid, ctl_err;
  bit   [7:0] out_data, out_mask;
  logic [2:0] level;
  logic [7:0] xz_cnt;

  logic       in_ready2, out_valid2, ctl_err2;
  bit   [7:0] out_data2, out_mask2;
  logic [2:0] level2;
  logic [1:0] xz_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] qd[$];
  logic [7:0] qm[$];
  int         cnt8, cnt2;
  bit         cerr;
  logic [7:0] last_d, last_m;

  always #5 clk = ~clk;

  xz_resolve_fifo #(.DEPTH(DEPTH), .FILL(1'b0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(din), .in_valid(vin),
    .in_ready(in_ready), .out_data(out_data), .out_mask(out_mask), .out_valid(out_valid),
    .out_ready(ordy), .level(level), .xz_cnt(xz_cnt), .ctl_err(ctl_err)
  );

  xz_resolve_fifo #(.DEPTH(DEPTH), .FILL(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(din), .in_valid(vin),
    .in_ready(in_ready2), .out_data(out_data2), .out_mask(out_mask2), .out_valid(out_valid2),
    .out_ready(ordy), .level(level2), .xz_cnt(xz_cnt2), .ctl_err(ctl_err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    qd.delete();
    qm.delete();
    cnt8   = 0;
    cnt2   = 0;
    cerr   = 1'b0;
    last_d = '0;
    last_m = '0;
  endtask

  // Applies one clock edge's worth of behaviour using the inputs as currently driven.
  task automatic model_edge();
    logic [7:0] rd, rm;
    bit         do_push, do_pop;
    if (!(vin === 1'b0 || vin === 1'b1)) cerr = 1'b1;
    if (flush) begin
      qd.delete();
      qm.delete();
    end else begin
      do_pop  = (qd.size() > 0) && (ordy === 1'b1);
      do_push = (vin === 1'b1) && (qd.size() < DEPTH);
      for (int i = 0; i < 8; i++) begin
        if (din[i] === 1'b0 || din[i] === 1'b1) begin
          rd[i] = din[i];
          rm[i] = 1'b0;
        end else begin
          rd[i] = 1'b0;
          rm[i] = 1'b1;
        end
      end
      if (do_pop) begin
        void'(qd.pop_front());
        void'(qm.pop_front());
      end
      if (do_push) begin
        qd.push_back(rd);
        qm.push_back(rm);
        if (rm != 0) begin
          if (cnt8 < 255) cnt8++;
          if (cnt2 < 3) cnt2++;
        end
      end
    end
    if (qd.size() > 0) begin
      last_d = qd[0];
      last_m = qm[0];
    end
  endtask

  task automatic check_all();
    check("level", 32'(level), 32'(qd.size()));
    check("out_valid", 32'(out_valid), 32'(qd.size() != 0));
    check("in_ready", 32'(in_ready), 32'(qd.size() != DEPTH));
    check("out_data", 32'(out_data), 32'(last_d));
    check("out_mask", 32'(out_mask), 32'(last_m));
    check("xz_cnt", 32'(xz_cnt), 32'(cnt8));
    check("ctl_err", 32'(ctl_err), 32'(cerr));
    check("level2", 32'(level2), 32'(qd.size()));
    check("out_valid2", 32'(out_valid2), 32'(qd.size() != 0));
    check("in_ready2", 32'(in_ready2), 32'(qd.size() != DEPTH));
    check("out_data2", 32'(out_data2), 32'(last_d));
    check("out_mask2", 32'(out_mask2), 32'(last_m));
    check("xz_cnt2", 32'(xz_cnt2), 32'(cnt2));
    check("ctl_err2", 32'(ctl_err2), 32'(cerr));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
    vin   = v;
    din   = d;
    ordy  = r;
    flush = f;
    cycle();
  endtask

  task automatic drive_random();
    int         sel;
    logic [7:0] d;
    sel = $urandom_range(0, 9);
    d   = 8'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) == 0) d[i] = 1'bx;
      end
    end
    vin   = (sel == 0) ? 1'bx : (sel < 6) ? 1'b1 : 1'b0;
    din   = d;
    ordy  = ($urandom_range(0, 2) != 0);
    flush = ($urandom_range(0, 39) == 0);
    cycle();
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();

    // Single clean beat: visible one cycle later with an all-zero mask
    @(negedge clk);
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    check("first_beat_data", 32'(out_data), 32'h5A);
    check("first_beat_valid", 32'(out_valid), 32'h1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Beat with unknown bits
    drive(1'b1, 8'b1x0x_0101, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to full with consumer stalled, then drain
    for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check("drain_order", 32'(out_data), 32'(i));
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Unknown valid, then flush: error flag survives the flush
    drive(1'bx, 8'h33, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);

    // Flush wins against a concurrent push with level 3
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    drive(1'b1, 8'hxx, 1'b0, 1'b1);
    check("flush_level", 32'(level), 32'd0);

    // Beats with unknown bits drive the counters toward saturation
    for (int i = 0; i < 6; i++) drive(1'b1, 8'b0000_000x, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) drive_random();

    // Asynchronous reset mid-stream with two beats buffered
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b1, 8'hA2, 1'b0, 1'b0);
    check("pre_reset_level", 32'(level), 32'd2);
    vin = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) drive_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xz_resolve_fifo.md
Name: xz_resolve_fifo

Overview:
- Downstream consumer stage for the generated design modules that drive 4-state packed buses shaped [4:3][3:0], such as the 8-bit `nfeep`-style outputs.
- Each accepted beat has every X/Z bit replaced by a fixed 2-state fill value. The stage records which bits were replaced and buffers the result in a small FIFO with valid/ready handshakes on both sides.
- It also keeps a saturating count of X/Z-contaminated beats and a sticky flag for 4-state corruption on the input control line.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- FILL, 1'b0, value substituted for any X or Z data bit.
- CNT_W, 8, width of the X/Z beat counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of FIFO contents.
- in_data  input  logic [4:3][3:0] (8)  4-state payload.
- in_valid  input  logic 1  producer beat valid; may itself be X/Z.
- in_ready  output  1  stage can accept a beat.
- out_data  output  bit [4:3][3:0] (8)  resolved 2-state payload at the FIFO head.
- out_mask  output  bit [4:3][3:0] (8)  1 where the head's original bit was X or Z.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head.
- level  output  $clog2(DEPTH)+1  current occupancy.
- xz_cnt  output  CNT_W  accepted beats with a nonzero mask; saturating.
- ctl_err  output  1  sticky flag: in_valid was X/Z on a clock edge.

Behaviour:
- Reset while rst_n is low, taking effect immediately and applicable mid-transfer:
  - read and write pointers = 0, level = 0, out_valid = 0;
  - out_data = 0, out_mask = 0;
  - xz_cnt = 0, ctl_err = 0.
- in_ready = (level != DEPTH). It is combinational from registered state, so it is 1 during and after reset.
- Valid qualification: in_valid counts as asserted only when it is exactly 1'b1. A value of 0 or X/Z means no push.
- ctl_err: set to 1 on any edge where in_valid is X or Z. It stays 1 until reset; flush does not clear it.
- Push occurs when in_valid === 1 and in_ready = 1.
- Per-bit resolution on push:
  - stored data bit = in_data bit if it is 0 or 1, else FILL;
  - stored mask bit = 1 if the in_data bit is X or Z, else 0.
- Pop occurs when out_valid = 1 and out_ready = 1.
- The FIFO is first-word-fall-through:
  - out_valid = (level != 0);
  - out_data and out_mask show the head entry;
  - the first push into an empty FIFO appears at the outputs on the next cycle, giving a latency of 1 cycle.
- With level = 0, out_data and out_mask hold their last value (0 after reset). Consumers must ignore them.
- Simultaneous push and pop with 0 < level < DEPTH: both happen and level is unchanged.
- Full (level = DEPTH): in_ready = 0, so there is no push even if a pop occurs in the same cycle. in_ready rises on the cycle after the pop.
- Empty (level = 0): no pop. A push makes level = 1 on the next edge.
- Pointers wrap modulo DEPTH. Each pointer carries one extra wrap bit, and level = wr - rd.
- flush = 1:
  - on the next edge the pointers and level become 0, regardless of push/pop in the same cycle (flush wins);
  - a beat presented in that cycle is dropped and is not counted in xz_cnt;
  - xz_cnt and ctl_err are unchanged.
- xz_cnt: increments by 1 on each push whose resolved mask != 0. It saturates at 2^CNT_W-1 and never wraps.
- Data is never altered between push and pop; ordering is strictly FIFO.

Test Plan:
- Reset release, then in_data = 8'h5A with in_valid = 1 for 1 cycle, out_ready = 1:
  - out_valid = 1 one cycle later with out_data = 8'h5A, out_mask = 8'h00;
  - xz_cnt = 0.
- in_data = 8'b1x0z_0101 pushed with FILL = 0:
  - out_data = 8'b1000_0101, out_mask = 8'b0101_0000;
  - xz_cnt = 1.
- out_ready = 0, five consecutive pushes of 8'h01..8'h05:
  - after 4 pushes in_ready = 0 and level = 4; 8'h05 is not accepted;
  - raising out_ready drains 01, 02, 03, 04 in order, and in_ready = 1 on the cycle after the first pop.
- in_valid driven 1'bx for 1 cycle:
  - no push, level unchanged;
  - ctl_err = 1 and remains 1 through a subsequent flush; it clears only on rst_n low.
- Level = 3, then flush = 1 concurrently with a push of 8'hzz:
  - next cycle level = 0, out_valid = 0, in_ready = 1;
  - xz_cnt unchanged.
- CNT_W = 2, six pushes with mask != 0:
  - xz_cnt reads 1, 2, 3, 3, 3, 3.
- Assert rst_n low mid-stream with level = 2:
  - outputs immediately out_valid = 0, level = 0, xz_cnt = 0, without waiting for a clock edge.
